fifo_sync: RTL and testbench
============================

Name: fifo_sync

Overview:
- Single-clock first-in first-out buffer, 16-bit words, depth 8 by default.
- Sits between a producer and a consumer that share one clock.
- Supplies full/empty status and a registered read-data output.
- Replaces the dual-clock variant where both sides run in the same domain.

Parameters:
- width, 16: data word width in bits.
- depth, 8: number of entries. Must be a power of two and at least 2.

Ports:
- clk_w  input  1  sole clock. Both write and read ports are sampled on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  width  write data.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- data_out  output  width  registered read data.
- FIFO_full  output  1  high when the FIFO holds depth entries.
- FIFO_empty  output  1  high when the FIFO holds 0 entries.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset:
  - On a rising clk_w edge with reset=1, clear write and read pointers.
  - data_out=0, FIFO_empty=1, FIFO_full=0.
  - Memory contents are not cleared.
  - Reset takes priority over wr_en and rd_en, including mid-operation. All stored data is discarded.
- Pointers:
  - Write and read pointers are log2(depth)+1 bits wide.
  - The low bits address memory; the MSB is the wrap bit.
  - Each pointer increments by 1 per accepted operation and wraps modulo 2*depth.
- Flags (combinational from registered pointers):
  - FIFO_empty when the two pointers are equal.
  - FIFO_full when the MSBs differ and the low bits are equal.
- Write acceptance:
  - Accepted when wr_en=1 and FIFO_full=0.
  - data_in is stored at wptr and wptr increments.
  - A write while full is dropped. No state changes for that write.
- Read acceptance:
  - Accepted when rd_en=1 and FIFO_empty=0.
  - data_out is loaded with mem[rptr] on that edge and rptr increments.
  - Read latency is 1 cycle: data is valid on data_out after the accepting edge.
  - A read while empty is ignored and data_out holds its value.
- data_out holds its last value whenever no read is accepted.
- Simultaneous wr_en and rd_en:
  - Neither full nor empty: both occur and the occupancy is unchanged.
  - Empty: only the write occurs. There is no fall-through; the new word is readable on a later cycle.
  - Full: only the read occurs. The write is dropped and FIFO_full deasserts next cycle.
- Flag timing: flags update in the cycle after the accepting edge.
- Ordering is strict FIFO across pointer wrap-around.

Optional Feature:
- Macro FIFO_ERR_FLAGS_EN.
- When defined, add two outputs:
  - overflow (1 bit): sticky, set on wr_en=1 while FIFO_full=1.
  - underflow (1 bit): sticky, set on rd_en=1 while FIFO_empty=1.
  - Both are cleared only by reset (to 0).
- When not defined, these ports and their logic are absent. Core behaviour is identical in both builds.

Decomposition:
- Package fifo_pkg holds:
  - default constants FIFO_WIDTH=16 and FIFO_DEPTH=8;
  - a helper for the address width (log2 of depth).
- One sub-module, fifo_mem: a depth x width register array.
  - Synchronous write port (we, waddr, wdata).
  - Synchronous registered read port (re, raddr, rdata).
- Pointer and flag logic stays in fifo_sync.

Test Plan:
- Reset then idle: assert reset for 1 edge -> data_out=0, FIFO_empty=1, FIFO_full=0.
- Read while empty: rd_en=1 for 8 cycles after reset -> data_out stays 0, FIFO_empty stays 1 (underflow=1 if FIFO_ERR_FLAGS_EN).
- Fill: write 1..8 on 8 consecutive edges -> FIFO_full=1 after the 8th. A 9th write of 9 is dropped (overflow=1 if enabled).
- Drain: rd_en=1 for 8 edges -> data_out sequence 1,2,...,8 one cycle after each read. FIFO_empty=1 after the last read; data_out holds 8.
- Concurrent streaming: wr_en=rd_en=1 while writing 1..8 starting from empty:
  - first edge is write-only;
  - thereafter data_out yields 1..7 in order, occupancy stays 1;
  - then drain the remaining 8.
- Wrap and mid-reset: write 6, read 6, write 5 (pointers wrap) -> reads return those 5 in order. Reset with 3 entries held -> FIFO_empty=1, data_out=0 next cycle.

Source files
------------

// File: rtl/fifo_sync_pkg.sv
// Shared constants and helpers for the single-clock FIFO (package fifo_pkg).
package fifo_pkg;

    localparam int FIFO_WIDTH = 16;
    localparam int FIFO_DEPTH = 8;

    // Address width for a power-of-two depth; the pointers carry one extra wrap bit.
    function automatic int addr_w(input int d);
        return (d <= 2) ? 1 : $clog2(d);
    endfunction

endpackage

// File: rtl/fifo_sync_if.sv
// Producer/consumer bus of the single-clock FIFO; the FIFO uses the slave side.
interface fifo_sync_if #(
    parameter int width = fifo_pkg::FIFO_WIDTH
) ();

    logic [width-1:0] data_in;
    logic             wr_en;
    logic             rd_en;
    logic [width-1:0] data_out;
    logic             FIFO_full;
    logic             FIFO_empty;

    modport master (
        output data_in, wr_en, rd_en,
        input  data_out, FIFO_full, FIFO_empty
    );

    modport slave (
        input  data_in, wr_en, rd_en,
        output data_out, FIFO_full, FIFO_empty
    );

endinterface

// File: rtl/fifo_sync_mem.sv
// depth x width register array: synchronous write port, registered read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int width = FIFO_WIDTH,
    parameter int depth = FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [addr_w(depth)-1:0]  waddr,
    input  logic [width-1:0]          wdata,
    input  logic                      re,
    input  logic [addr_w(depth)-1:0]  raddr,
    output logic [width-1:0]          rdata
);

    logic [width-1:0] mem_q [depth];
    logic [width-1:0] rdata_q;

    // Storage is deliberately left out of reset; only the output register clears.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO: wrap-bit pointers, full/empty flags, registered read data.
// Optional sticky overflow/underflow outputs are enabled by defining FIFO_ERR_FLAGS_EN.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int width = FIFO_WIDTH,
    parameter int depth = FIFO_DEPTH
) (
    input  logic        clk_w,
    input  logic        reset,
`ifdef FIFO_ERR_FLAGS_EN
    output logic        overflow,
    output logic        underflow,
`endif
    fifo_sync_if.slave  fif
);

    localparam int AW = addr_w(depth);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             full;
    logic             empty;
    logic             wr_acc;
    logic             rd_acc;
    logic [width-1:0] rdata;

    // Equal pointers mean empty; same slot on opposite laps means full.
    assign empty  = (wptr_q == rptr_q);
    assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign wr_acc = fif.wr_en && !full;
    assign rd_acc = fif.rd_en && !empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_acc) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rptr_d = rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_w) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    fifo_mem #(
        .width (width),
        .depth (depth)
    ) u_mem (
        .clk   (clk_w),
        .rst   (reset),
        .we    (wr_acc && !reset),
        .waddr (wptr_q[AW-1:0]),
        .wdata (fif.data_in),
        .re    (rd_acc && !reset),
        .raddr (rptr_q[AW-1:0]),
        .rdata (rdata)
    );

    assign fif.data_out   = rdata;
    assign fif.FIFO_full  = full;
    assign fif.FIFO_empty = empty;

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q;
    logic udf_q;

    // Sticky until reset: record any request the FIFO had to refuse.
    always_ff @(posedge clk_w) begin
        if (reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q || (fif.wr_en && full);
            udf_q <= udf_q || (fif.rd_en && empty);
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// Self-checking bench for fifo_sync: queue-based reference model and scoreboard.
module tb_fifo_sync;
    import fifo_pkg::*;

    localparam int W = FIFO_WIDTH;
    localparam int D = FIFO_DEPTH;

    logic clk_w = 1'b0;
    logic reset = 1'b1;

    fifo_sync_if #(.width(W)) fif ();

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow;
    logic underflow;
`endif

    fifo_sync #(
        .width (W),
        .depth (D)
    ) dut (
        .clk_w     (clk_w),
        .reset     (reset),
`ifdef FIFO_ERR_FLAGS_EN
        .overflow  (overflow),
        .underflow (underflow),
`endif
        .fif       (fif)
    );

    always #5 clk_w = ~clk_w;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] mem_m [$];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] dout_m = '0;
    logic [W-1:0] exp_v;
    bit           ovf_m  = 1'b0;
    bit           udf_m  = 1'b0;
    bit           rd_fired;

    // Apply one cycle of stimulus, advance the model, then sample 1 time unit after the edge.
    task automatic drive(input bit rst, input bit wr, input bit rd, input logic [W-1:0] din);
        bit full_m;
        bit empty_m;
        reset       = rst;
        fif.wr_en   = wr;
        fif.rd_en   = rd;
        fif.data_in = din;
        rd_fired    = 1'b0;
        if (rst) begin
            mem_m.delete();
            exp_q.delete();
            dout_m = '0;
            ovf_m  = 1'b0;
            udf_m  = 1'b0;
        end else begin
            full_m  = (mem_m.size() == D);
            empty_m = (mem_m.size() == 0);
            if (wr && full_m)  ovf_m = 1'b1;
            if (rd && empty_m) udf_m = 1'b1;
            if (rd && !empty_m) begin
                dout_m = mem_m.pop_front();
                exp_q.push_back(dout_m);
                rd_fired = 1'b1;
            end
            if (wr && !full_m) mem_m.push_back(din);
        end
        @(posedge clk_w);
        #1;
        reset     = 1'b0;
        fif.wr_en = 1'b0;
        fif.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, '0);
        vectors++;
        if (fif.data_out !== '0) begin
            miscompares++; $display("FAIL reset_dout: got %h expected 0", fif.data_out);
        end
        vectors++;
        if (fif.FIFO_empty !== 1'b1) begin
            miscompares++; $display("FAIL reset_empty: got %b expected 1", fif.FIFO_empty);
        end
        vectors++;
        if (fif.FIFO_full !== 1'b0) begin
            miscompares++; $display("FAIL reset_full: got %b expected 0", fif.FIFO_full);
        end
`ifdef FIFO_ERR_FLAGS_EN
        vectors++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            miscompares++; $display("FAIL reset_errflags: got %b%b expected 00", overflow, underflow);
        end
`endif
    endtask

    task automatic test_read_empty();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 1'b1, '0);
            vectors++;
            if (fif.data_out !== '0 || fif.FIFO_empty !== 1'b1) begin
                miscompares++;
                $display("FAIL rd_empty[%0d]: got dout=%h empty=%b expected dout=0 empty=1",
                         i, fif.data_out, fif.FIFO_empty);
            end
        end
`ifdef FIFO_ERR_FLAGS_EN
        vectors++;
        if (underflow !== udf_m) begin
            miscompares++; $display("FAIL underflow: got %b expected %b", underflow, udf_m);
        end
`endif
    endtask

    task automatic test_fill();
        for (int i = 1; i <= D; i++) begin
            drive(1'b0, 1'b1, 1'b0, W'(i));
            vectors++;
            if (fif.FIFO_full !== (i == D) || fif.FIFO_empty !== 1'b0) begin
                miscompares++;
                $display("FAIL fill[%0d]: got full=%b empty=%b expected full=%b empty=0",
                         i, fif.FIFO_full, fif.FIFO_empty, (i == D));
            end
        end
        drive(1'b0, 1'b1, 1'b0, W'(9));
        vectors++;
        if (fif.FIFO_full !== 1'b1 || fif.data_out !== dout_m) begin
            miscompares++;
            $display("FAIL fill_drop: got full=%b dout=%h expected full=1 dout=%h",
                     fif.FIFO_full, fif.data_out, dout_m);
        end
`ifdef FIFO_ERR_FLAGS_EN
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++; $display("FAIL overflow: got %b expected 1", overflow);
        end
`endif
    endtask

    task automatic test_drain();
        for (int i = 1; i <= D; i++) begin
            drive(1'b0, 1'b0, 1'b1, '0);
            if (rd_fired) begin
                exp_v = exp_q.pop_front();
                vectors++;
                if (fif.data_out !== exp_v || fif.data_out !== W'(i)) begin
                    miscompares++;
                    $display("FAIL drain[%0d]: got %h expected %h", i, fif.data_out, exp_v);
                end
            end
        end
        vectors++;
        if (fif.FIFO_empty !== 1'b1 || fif.FIFO_full !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_flags: got empty=%b full=%b expected empty=1 full=0",
                     fif.FIFO_empty, fif.FIFO_full);
        end
        drive(1'b0, 1'b0, 1'b0, '0);
        vectors++;
        if (fif.data_out !== W'(D)) begin
            miscompares++; $display("FAIL drain_hold: got %h expected %h", fif.data_out, W'(D));
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b1, 1'b1, W'(i));
            if (i == 1) begin
                vectors++;
                if (rd_fired || fif.data_out !== W'(D)) begin
                    miscompares++;
                    $display("FAIL stream_first: got dout=%h expected %h (write only)",
                             fif.data_out, W'(D));
                end
            end else begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                vectors++;
                if (fif.data_out !== exp_v || fif.data_out !== W'(i - 1)) begin
                    miscompares++;
                    $display("FAIL stream[%0d]: got %h expected %h", i, fif.data_out, W'(i - 1));
                end
            end
            vectors++;
            if (fif.FIFO_empty !== 1'b0 || fif.FIFO_full !== 1'b0) begin
                miscompares++;
                $display("FAIL stream_flags[%0d]: got empty=%b full=%b expected 0 0",
                         i, fif.FIFO_empty, fif.FIFO_full);
            end
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b1, '0);
            if (rd_fired) void'(exp_q.pop_front());
            vectors++;
            if (fif.data_out !== W'(8) || fif.FIFO_empty !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_tail[%0d]: got dout=%h empty=%b expected dout=0008 empty=1",
                         i, fif.data_out, fif.FIFO_empty);
            end
        end
    endtask

    task automatic test_wrap_reset();
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 1'b0, W'(16'h0100 + i));
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b1, '0);
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            vectors++;
            if (fif.data_out !== exp_v || fif.data_out !== W'(16'h0100 + i)) begin
                miscompares++;
                $display("FAIL wrap_a[%0d]: got %h expected %h", i, fif.data_out, W'(16'h0100 + i));
            end
        end
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, W'(16'h0200 + i));
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, '0);
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            vectors++;
            if (fif.data_out !== exp_v || fif.data_out !== W'(16'h0200 + i)) begin
                miscompares++;
                $display("FAIL wrap_b[%0d]: got %h expected %h", i, fif.data_out, W'(16'h0200 + i));
            end
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, W'(16'h0300 + i));
        drive(1'b1, 1'b1, 1'b1, W'(16'h0399));
        vectors++;
        if (fif.FIFO_empty !== 1'b1 || fif.FIFO_full !== 1'b0 || fif.data_out !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: got empty=%b full=%b dout=%h expected empty=1 full=0 dout=0",
                     fif.FIFO_empty, fif.FIFO_full, fif.data_out);
        end
`ifdef FIFO_ERR_FLAGS_EN
        vectors++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            miscompares++; $display("FAIL mid_reset_err: got %b%b expected 00", overflow, underflow);
        end
`endif
        drive(1'b0, 1'b0, 1'b1, '0);
        vectors++;
        if (fif.data_out !== '0 || fif.FIFO_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_rd: got dout=%h empty=%b expected dout=0 empty=1",
                     fif.data_out, fif.FIFO_empty);
        end
        drive(1'b0, 1'b1, 1'b0, W'(16'hABCD));
        drive(1'b0, 1'b0, 1'b1, '0);
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        vectors++;
        if (fif.data_out !== exp_v || fif.data_out !== W'(16'hABCD)) begin
            miscompares++;
            $display("FAIL post_reset_wr: got %h expected %h", fif.data_out, W'(16'hABCD));
        end
        vectors++;
        if (exp_q.size() != 0 || mem_m.size() != 0 || fif.FIFO_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL final_state: got empty=%b pending=%0d expected empty=1 pending=0",
                     fif.FIFO_empty, exp_q.size());
        end
    endtask

    initial begin
        fif.data_in = '0;
        fif.wr_en   = 1'b0;
        fif.rd_en   = 1'b0;
        test_reset();
        test_read_empty();
        test_fill();
        test_drain();
        test_back_to_back();
        test_wrap_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
